// File: rtl/sfp_vec3_sub_pipe.sv
// Two-stage pipelined 3-component fixed-point subtractor with fraction/integer resize,
// valid/ready handshake and range-violation statistics.
module sfp_vec3_sub_pipe #(
  parameter int IW_IN  = 3,
  parameter int QW_IN  = 4,
  parameter int IW_OUT = 3,
  parameter int QW_OUT = 2,
  parameter int CLIP   = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [IW_IN+QW_IN:0]       a_x,
  input  logic [IW_IN+QW_IN:0]       a_y,
  input  logic [IW_IN+QW_IN:0]       a_z,
  input  logic [IW_IN+QW_IN:0]       b_x,
  input  logic [IW_IN+QW_IN:0]       b_y,
  input  logic [IW_IN+QW_IN:0]       b_z,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [IW_OUT+QW_OUT:0]     d_x,
  output logic [IW_OUT+QW_OUT:0]     d_y,
  output logic [IW_OUT+QW_OUT:0]     d_z,
  output logic                       out_clip,
  output logic                       clip_sticky,
  output logic [15:0]                clip_count,
  input  logic                       clip_clr
);
  localparam int WI  = IW_IN + QW_IN + 1;
  localparam int WO  = IW_OUT + QW_OUT + 1;
  localparam int WD  = WI + 1;
  localparam int SHR = (QW_OUT < QW_IN) ? (QW_IN - QW_OUT) : 0;
  localparam int SHL = (QW_OUT >= QW_IN) ? (QW_OUT - QW_IN) : 0;
  localparam int WB  = WD + SHL;
  localparam int WC  = ((WB > WO) ? WB : WO) + 1;
  // Output range limits expressed in the widened compare domain.
  localparam logic signed [WC-1:0] MAXC = signed'({{(WC-WO+1){1'b0}}, {(WO-1){1'b1}}});
  localparam logic signed [WC-1:0] MINC = signed'({{(WC-WO+1){1'b1}}, {(WO-1){1'b0}}});

  logic [2:0][WI-1:0] w_a;
  logic [2:0][WI-1:0] w_b;
  logic [2:0][WD-1:0] r_s1_d;
  logic [2:0][WO-1:0] w_res;
  logic [2:0]         w_viol;
  logic [2:0][WO-1:0] r_s2_d;
  logic               r_s1_v;
  logic               r_s2_v;
  logic               r_s2_clip;
  logic               r_sticky;
  logic [15:0]        r_count;
  logic               w_s1_adv;
  logic               w_in_xfer;
  logic               w_out_xfer;

  assign w_a = {a_z, a_y, a_x};
  assign w_b = {b_z, b_y, b_x};

  assign w_s1_adv   = !r_s2_v || out_ready;
  assign in_ready   = !r_s1_v || w_s1_adv;
  assign w_in_xfer  = in_valid && in_ready;
  assign w_out_xfer = r_s2_v && out_ready;

  for (genvar g = 0; g < 3; g++) begin : g_comp
    logic signed [WB-1:0] w_sh;
    logic signed [WC-1:0] w_c;
    logic                 w_hi;
    logic                 w_lo;

    // Arithmetic right shift floors toward minus infinity when dropping LSBs.
    assign w_sh = (WB'(signed'(r_s1_d[g])) >>> SHR) <<< SHL;
    assign w_c  = WC'(w_sh);
    assign w_hi = w_c > MAXC;
    assign w_lo = w_c < MINC;
    assign w_viol[g] = w_hi || w_lo;
    assign w_res[g]  = (CLIP != 0 && w_hi) ? MAXC[WO-1:0] :
                       (CLIP != 0 && w_lo) ? MINC[WO-1:0] : w_c[WO-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_v <= 1'b0;
      r_s1_d <= '0;
    end else begin
      if (in_ready) r_s1_v <= in_valid;
      if (w_in_xfer) begin
        for (int k = 0; k < 3; k++)
          r_s1_d[k] <= WD'(signed'(w_a[k])) - WD'(signed'(w_b[k]));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_v    <= 1'b0;
      r_s2_d    <= '0;
      r_s2_clip <= 1'b0;
    end else if (w_s1_adv) begin
      r_s2_v <= r_s1_v;
      if (r_s1_v) begin
        r_s2_d    <= w_res;
        r_s2_clip <= |w_viol;
      end
    end
  end

  // A clear in the same cycle as a clipped transfer takes priority.
  always_ff @(posedge clk) begin
    if (rst || clip_clr) begin
      r_sticky <= 1'b0;
      r_count  <= '0;
    end else if (w_out_xfer && r_s2_clip) begin
      r_sticky <= 1'b1;
      if (r_count != 16'hFFFF) r_count <= r_count + 16'd1;
    end
  end

  assign out_valid   = r_s2_v;
  assign d_x         = r_s2_d[0];
  assign d_y         = r_s2_d[1];
  assign d_z         = r_s2_d[2];
  assign out_clip    = r_s2_clip;
  assign clip_sticky = r_sticky;
  assign clip_count  = r_count;
endmodule

// File: doc/sfp_vec3_sub_pipe.md
SFP_VEC3_SUB_PIPE -- requirements
Module: sfp_vec3_sub_pipe

Interface
REQ-001 SHALL have parameters, one per line: IW_IN, 3, input integer bits excluding sign; QW_IN, 4, input fractional bits; IW_OUT, 3, output integer bits; QW_OUT, 2, output fractional bits; CLIP, 1, integer reduction mode where 0 = wrap and 1 = clip.
REQ-002 SHALL have one clock; reset is synchronous and active-high; ports are clk and rst.
REQ-003 SHALL use input width WI = IW_IN+QW_IN+1 and output width WO = IW_OUT+QW_OUT+1, all two's-complement signed.
REQ-004 Ports, one per line (name, direction, width, meaning):
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- in_valid  in  1  input vector valid
- in_ready  out  1  block accepts input this cycle
- a_x, a_y, a_z  in  WI each  minuend components
- b_x, b_y, b_z  in  WI each  subtrahend components
- out_valid  out  1  result vector valid
- out_ready  in  1  consumer accepts result
- d_x, d_y, d_z  out  WO each  result = a - b, resized
- out_clip  out  1  at least one component of this result clipped or wrapped
- clip_sticky  out  1  set on any accepted clipped result
- clip_count  out  16  number of clipped results accepted by the consumer
- clip_clr  in  1  clears clip_sticky and clip_count

Function
REQ-005 Stage 1 SHALL register the full-precision difference per component: IW_IN+1 integer bits, QW_IN fractional bits, no overflow possible.
REQ-006 Stage 2 SHALL register the resized result and the OR of the per-component range violations.
REQ-007 Fraction resize: if QW_OUT < QW_IN, the block SHALL drop LSBs, rounding toward minus infinity; if QW_OUT >= QW_IN, it SHALL zero-pad.
REQ-008 Integer resize, CLIP=1: values above max SHALL saturate to 2^IW_OUT - 2^-QW_OUT, and values below min SHALL saturate to -2^IW_OUT.
REQ-009 Integer resize, CLIP=0: the block SHALL keep the low WO bits (wrap).
REQ-010 Range violation SHALL be flagged in both modes, and only when the integer range is exceeded; fractional truncation alone SHALL NOT flag.
REQ-011 Handshake rules:
- A transfer occurs when valid and ready are both high.
- in_ready SHALL be high when stage 1 is empty or stage 1 advances this cycle.
- Stage 1 SHALL advance when stage 2 is empty or out_ready is high.
- in_ready SHALL NOT combinationally depend on in_valid.
REQ-012 Latency SHALL be 2 cycles from an input transfer to out_valid, with out_ready held high.
REQ-013 Throughput SHALL be 1 vector per cycle with out_ready held high.
REQ-014 Output stability: while out_valid=1 and out_ready=0, d_*, out_clip and out_valid SHALL hold stable.
REQ-015 Input capture: data SHALL be captured only on an input transfer; no vector SHALL be dropped or duplicated under any out_ready pattern.
REQ-016 On each output transfer with out_clip=1, the block SHALL set clip_sticky and increment clip_count, saturating at 0xFFFF.
REQ-017 If clip_clr and a clipped output transfer occur in the same cycle, clip_clr SHALL win: sticky=0, count=0.
REQ-018 Parameter combinations SHALL be legal in any direction, including IW_OUT > IW_IN+1 (sign extension, never flags).

Reset
REQ-019 On rst=1 at a clock edge, both stage valids SHALL be cleared: out_valid=0, in_ready=1 on the next cycle.
REQ-020 On reset, out_clip=0, d_*=0, clip_sticky=0 and clip_count=0.
REQ-021 Reset asserted mid-stream SHALL discard all in-flight vectors, with no output transfer and no counter update in that cycle.
REQ-022 Outputs SHALL be defined in the first cycle after reset deasserts.

Verification (defaults WI=8, WO=6)
REQ-023 Setup: CLIP=1, out_ready=1, a_x=0x70 (7.0), b_x=0xE0 (-2.0), other components 0. Required: after 2 cycles d_x=0x1F (7.75), out_clip=1, clip_count=1.
REQ-024 Setup: CLIP=0, same stimulus as REQ-023. Required: d_x=0x24 (-7.0), out_clip=1.
REQ-025 Truncation: a_x=0x07 (0.4375), b_x=0 gives d_x=0x01 (0.25) with out_clip=0; a_x=0xFF (-0.0625), b_x=0 gives d_x=0x3F (-0.25) with out_clip=0.
REQ-026 Backpressure: stream 8 vectors with out_ready toggling pseudo-randomly. Required: all 8 results emerge in order, unchanged while stalled; in_ready=0 only when both stages are full and out_ready=0.
REQ-027 Reset mid-stream: assert rst with 2 vectors in flight. Required: out_valid=0 next cycle, clip_count=0, and no stale result after release.
REQ-028 Counter: force 0xFFFF clipped transfers. Required: count holds 0xFFFF. Then clip_clr in the same cycle as a clipped transfer. Required: count=0, sticky=0.
